// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the core data-memory bridge.
// Helpers work on a 64-bit superset; callers truncate to their XLEN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] ST_B = 2'd0;
  localparam logic [1:0] ST_H = 2'd1;
  localparam logic [1:0] ST_W = 2'd2;
  localparam logic [1:0] ST_D = 2'd3;

  // off is the byte offset already masked to the bus width
  function automatic logic misaligned(input logic [1:0] st, input logic [2:0] off,
                                      input int xlen);
    logic bad;
    case (st)
      ST_B:    bad = 1'b0;
      ST_H:    bad = off[0];
      ST_W:    bad = |off[1:0];
      default: bad = (xlen == 32) || (|off);
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] strb_gen(input logic [1:0] st, input logic [2:0] off,
                                          input logic load, input int xlen);
    logic [7:0] full;
    logic [7:0] s;
    full = (xlen == 64) ? 8'hFF : 8'h0F;
    case (st)
      ST_B:    s = 8'h01 << off;
      ST_H:    s = 8'h03 << off;
      ST_W:    s = 8'h0F << off;
      default: s = full;
    endcase
    return load ? full : s;
  endfunction

  function automatic logic [63:0] lane_replicate(input logic [1:0] st, input logic [63:0] w);
    logic [63:0] r;
    case (st)
      ST_B:    r = {8{w[7:0]}};
      ST_H:    r = {4{w[15:0]}};
      ST_W:    r = {2{w[31:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_dmem_bridge_if.sv
// Valid/ready data-bus bundle: request channel from the bridge, response channel back.
// The bridge is the master side, the memory model or interconnect the slave side.
interface core_dmem_bridge_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              bus_req_vld;
  logic              bus_req_rdy;
  logic              bus_req_we;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [XLEN-1:0]   bus_req_wdata;
  logic [XLEN/8-1:0] bus_req_strb;
  logic              bus_rsp_vld;
  logic [XLEN-1:0]   bus_rsp_data;
  logic              bus_rsp_err;

  modport master (
    output bus_req_vld, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
    input  bus_req_rdy, bus_rsp_vld, bus_rsp_data, bus_rsp_err
  );

  modport slave (
    input  bus_req_vld, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_strb,
    output bus_req_rdy, bus_rsp_vld, bus_rsp_data, bus_rsp_err
  );
endinterface

// File: rtl/dmem_lane_gen.sv
// Combinational store-lane shaping: aligned address, byte strobes, replicated data, misalignment.
// Zero latency, no state, no flow control.
module dmem_lane_gen
  import dmem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [1:0]        str_type,
  output logic [ADDR_W-1:0] addr_aligned,
  output logic [XLEN/8-1:0] strb,
  output logic [XLEN-1:0]   wdata_rep,
  output logic              misalign
);
  localparam int NB = XLEN / 8;
  localparam logic [2:0] OFF_MASK = 3'(NB - 1);

  logic [2:0] off;

  assign off          = addr[2:0] & OFF_MASK;
  assign addr_aligned = addr & ~ADDR_W'(NB - 1);
  // loads always fetch the whole aligned word, so they can never be misaligned
  assign misalign     = !load && misaligned(str_type, off, XLEN);
  assign strb         = NB'(strb_gen(str_type, off, load, XLEN));
  assign wdata_rep    = XLEN'(lane_replicate(str_type, 64'(wdata)));

endmodule

// File: rtl/core_dmem_bridge.sv
// Bridges the core's combinational data port onto a valid/ready bus, stalling the core until DONE.
// Minimum 3-cycle access (REQ, WAIT, DONE); holds the request while bus_req_rdy is low.
module core_dmem_bridge
  import dmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               core_rd,
  input  logic               core_wr,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [XLEN-1:0]    core_wdata,
  input  logic [1:0]         core_str_type,
  output logic [XLEN-1:0]    core_rdata,
  output logic               core_stall,
  output logic               core_err,
  core_dmem_bridge_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [NB-1:0]     req_strb;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt;

  logic [ADDR_W-1:0] lg_addr;
  logic [NB-1:0]     lg_strb;
  logic [XLEN-1:0]   lg_wdata;
  logic              lg_misalign;

  logic req_any;
  logic dec_err;
  logic launch;
  logic timeout_hit;
  logic req_vld;

  dmem_lane_gen #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_lane (
    .load         (core_rd),
    .addr         (core_addr),
    .wdata        (core_wdata),
    .str_type     (core_str_type),
    .addr_aligned (lg_addr),
    .strb         (lg_strb),
    .wdata_rep    (lg_wdata),
    .misalign     (lg_misalign)
  );

  assign req_any     = core_rd ^ core_wr;
  assign dec_err     = (core_rd & core_wr) | (core_wr & lg_misalign);
  assign launch      = (state == IDLE) && req_any && !dec_err;
  assign timeout_hit = (TIMEOUT != 0) && ((cnt + CW'(1)) == CW'(TIMEOUT));
  assign req_vld     = !reset && (state == REQ);

  // Payload is zeroed outside REQ so the bus never sees stale addresses or data.
  assign bus.bus_req_vld   = req_vld;
  assign bus.bus_req_we    = req_vld && req_we;
  assign bus.bus_req_addr  = req_vld ? req_addr  : '0;
  assign bus.bus_req_strb  = req_vld ? req_strb  : '0;
  assign bus.bus_req_wdata = req_vld ? req_wdata : '0;

  always_comb begin
    core_stall = 1'b0;
    core_err   = 1'b0;
    core_rdata = '0;
    if (!reset) begin
      core_stall = launch || (state == REQ) || (state == WAIT);
      core_err   = ((state == IDLE) && dec_err) || ((state == DONE) && err_q);
      if (state == DONE) core_rdata = rdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_strb  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= REQ;
            req_we    <= core_wr;
            req_addr  <= lg_addr;
            req_strb  <= lg_strb;
            req_wdata <= lg_wdata;
            rdata_q   <= '0;
            err_q     <= 1'b0;
          end
        end
        REQ: begin
          if (bus.bus_req_rdy) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (bus.bus_rsp_vld) begin
            state   <= DONE;
            rdata_q <= req_we ? '0 : bus.bus_rsp_data;
            err_q   <= bus.bus_rsp_err;
          end else if (timeout_hit) begin
            state   <= DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/core_dmem_bridge.md
Name: core_dmem_bridge

Overview:
Sits between the single-cycle core's combinational data-memory port (read, write, ALU address, write data, store type) and a latency-tolerant valid/ready data bus. Stalls the core while a transaction is outstanding, generates byte strobes and lane-replicated write data, and reports misaligned accesses, bus errors and timeouts. Replaces the zero-latency memory hookup so the core can be tested against memories with arbitrary response delay.

Parameters:
XLEN, 32, data width in bits; legal values are 32 and 64.
ADDR_W, 32, address width in bits.
TIMEOUT, 16, maximum number of WAIT cycles before a timeout error; 0 disables the timeout.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
core_rd  in  1  core load request.
core_wr  in  1  core store request.
core_addr  in  ADDR_W  byte address (ALU output).
core_wdata  in  XLEN  store data, right-aligned.
core_str_type  in  2  store size: 0 = byte, 1 = half, 2 = word, 3 = dword.
core_rdata  out  XLEN  full aligned read word; valid in DONE.
core_stall  out  1  freeze the core.
core_err  out  1  one-cycle error pulse.
bus_req_vld  out  1  request valid.
bus_req_rdy  in  1  request accepted.
bus_req_we  out  1  1 = write.
bus_req_addr  out  ADDR_W  address aligned down to XLEN/8.
bus_req_wdata  out  XLEN  lane-replicated write data.
bus_req_strb  out  XLEN/8  byte enables.
bus_rsp_vld  in  1  response or write-ack valid.
bus_rsp_data  in  XLEN  read data.
bus_rsp_err  in  1  bus error, qualified by bus_rsp_vld.

Behaviour:
- Reset: state goes to IDLE. All bus_req_* outputs, core_rdata and core_err are 0. core_stall is 0 while reset is high. A reset asserted in any state aborts the transaction at the next edge, with no further bus activity.
- Request decode (IDLE only):
  - A request is valid when core_rd XOR core_wr.
  - An error is raised for: core_rd and core_wr both high; a misaligned store (half with addr[0] != 0; word with addr[1:0] != 0; dword with addr[2:0] != 0); or core_str_type = 3 with XLEN = 32.
  - On error: core_err pulses for one cycle, there is no stall and no bus request.
  - Loads are never misaligned; they always fetch the full aligned word with all strobes set.
- core_stall: combinational. It is 1 in IDLE when a valid, error-free request is present, and 1 in REQ and WAIT. It is 0 in DONE.
- FSM:
  - IDLE -> REQ: on a valid request. Capture we, aligned address, strobe and replicated wdata into registers.
  - REQ: bus_req_vld = 1 with registered payload. Payload stays stable until bus_req_rdy. REQ -> WAIT on vld & rdy. bus_rsp_vld is ignored in REQ, so the bus must respond no earlier than the cycle after acceptance.
  - WAIT: a counter increments each cycle. On bus_rsp_vld, capture bus_rsp_data (reads) and bus_rsp_err, then -> DONE. If TIMEOUT != 0 and the counter reaches TIMEOUT without a response, -> DONE with err = 1 and rdata = 0.
  - DONE: one cycle. core_stall = 0, core_rdata = captured data, core_err = captured error. The core completes its instruction this cycle. DONE -> IDLE unconditionally; the still-present core request is not relaunched.
- Stray bus_rsp_vld in IDLE or DONE (for example a late response after a timeout) is ignored.
- Strobe and data, where o = addr offset within XLEN/8:
  - Byte: strb = 1 << o; wdata = wdata[7:0] replicated across all lanes.
  - Half: strb = 2'b11 << o; wdata = wdata[15:0] replicated.
  - Word: strb = 4'hF << o; wdata = wdata[31:0] replicated.
  - Dword: all strobe bits set; wdata passed through unchanged.
- Timeout counter width is $clog2(TIMEOUT+1). The counter clears on entry to WAIT.

Decomposition:
- Package dmem_pkg holds:
  - state enum: IDLE, REQ, WAIT, DONE;
  - store-type constants: ST_B = 0, ST_H = 1, ST_W = 2, ST_D = 3;
  - functions misaligned(), strb_gen() and lane_replicate(), parametrised by XLEN.
- One sub-module, dmem_lane_gen: combinational strobe, replication and misalignment logic. The FSM, counter and registers stay in core_dmem_bridge.

Test Plan:
- Word store at 0x104 with data 0xDEADBEEF; rdy in the first REQ cycle; rsp 2 cycles later -> bus_req_vld for 1 cycle, addr 0x104, strb 4'hF, wdata 0xDEADBEEF; stall high from the request cycle through WAIT; stall low and err = 0 in DONE.
- Byte store at 0x103 with data 0x000000AB -> strb 4'b1000, wdata 0xABABABAB, addr 0x100. Half store at 0x102 with data 0x1234 -> strb 4'b1100, wdata 0x12341234.
- Half store at 0x101; separately, rd and wr both high -> core_err = 1 for exactly one cycle in each case, bus_req_vld never asserted, stall = 0.
- Load at 0x206 with rdy held low for 3 cycles -> vld held, addr 0x204 and strb 4'hF stable. Rsp data 0x12345678 with rsp_err = 1 -> core_rdata 0x12345678 and core_err = 1 in DONE.
- TIMEOUT = 4, load with no response -> DONE after 4 WAIT cycles with err = 1 and rdata 0. An rsp_vld 2 cycles later is ignored and does not change state or outputs.
- Reset asserted in WAIT -> IDLE next cycle with vld = 0 and stall = 0. Then, with XLEN = 64, dword store at 0x108 -> strb 8'hFF. Dword store at 0x10C -> error pulse, no request.
